// File: rtl/cv32e40p_obi_data_arbiter.sv
// Two-to-one OBI data arbiter (LSU = port 0, XIF memory path = port 1) with in-order response routing.
// Request/grant and response paths are combinational (0 added cycles); m_req_o drops while the route FIFO is full.
module cv32e40p_obi_data_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ARB_MODE        = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               s0_req_i,
  output logic                               s0_gnt_o,
  input  logic                               s0_we_i,
  input  logic [3:0]                         s0_be_i,
  input  logic [31:0]                        s0_addr_i,
  input  logic [31:0]                        s0_wdata_i,
  output logic                               s0_rvalid_o,
  output logic [31:0]                        s0_rdata_o,
  input  logic                               s1_req_i,
  output logic                               s1_gnt_o,
  input  logic                               s1_we_i,
  input  logic [3:0]                         s1_be_i,
  input  logic [31:0]                        s1_addr_i,
  input  logic [31:0]                        s1_wdata_i,
  output logic                               s1_rvalid_o,
  output logic [31:0]                        s1_rdata_o,
  output logic                               m_req_o,
  input  logic                               m_gnt_i,
  input  logic                               m_rvalid_i,
  output logic                               m_we_o,
  output logic [3:0]                         m_be_o,
  output logic [31:0]                        m_addr_o,
  output logic [31:0]                        m_wdata_o,
  input  logic [31:0]                        m_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                     state_q, state_d;
  logic                       lock_id_q, lock_id_d;
  logic                       last_id_q;
  logic                       err_q;
  logic [MAX_OUTSTANDING-1:0] route_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q;

  logic arb_sel, sel, sel_req, not_full, push, pop, head;

  always_comb begin
    arb_sel = s1_req_i && !s0_req_i;
    if (s0_req_i && s1_req_i) begin
      arb_sel = (ARB_MODE == 1) ? 1'b0 : ~last_id_q;
    end
  end

  // A presented request stays selected until the bus takes it.
  assign sel      = (state_q == LOCKED) ? lock_id_q : arb_sel;
  assign sel_req  = sel ? s1_req_i : s0_req_i;
  assign not_full = (count_q < CNT_MAX);
  assign m_req_o  = sel_req && not_full;
  assign push     = m_req_o && m_gnt_i;
  assign pop      = m_rvalid_i && (count_q != '0);
  assign head     = route_q[rd_ptr_q];

  assign m_we_o    = sel ? s1_we_i    : s0_we_i;
  assign m_be_o    = sel ? s1_be_i    : s0_be_i;
  assign m_addr_o  = sel ? s1_addr_i  : s0_addr_i;
  assign m_wdata_o = sel ? s1_wdata_i : s0_wdata_i;

  assign s0_rdata_o    = m_rdata_i;
  assign s1_rdata_o    = m_rdata_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      lock_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: begin
        if (m_req_o && !m_gnt_i) begin
          state_d   = LOCKED;
          lock_id_d = sel;
        end
      end
      LOCKED: begin
        if (push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s0_gnt_o    = push && !sel;
    s1_gnt_o    = push && sel;
    s0_rvalid_o = pop && !head;
    s1_rvalid_o = pop && head;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_id_q <= 1'b1;
      err_q     <= 1'b0;
      route_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      if (push) begin
        last_id_q         <= sel;
        route_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A response with nothing outstanding has no owner; flag it until reset.
      if (m_rvalid_i && (count_q == '0)) err_q <= 1'b1;
    end
  end

endmodule
